// File: rtl/uart_ram_ctrl.sv
// uart_ram_ctrl: UART command sequencer and sole master of the 128x32 RAM.
// Command byte {we,addr[6:0]}; writes take 4 big-endian data bytes,
// reads stream the word back MSB first through the transmitter.
// Optional: define UART_RAM_CTRL_WRACK_EN to send 0xA5 after each write.
// Ports:
//   clk, rst            clock, sync active-high reset
//   rx_data, rx_valid   received byte strobe
//   tx_data, tx_start   transmit request (tx_start only when !tx_busy)
//   tx_busy             transmitter busy
//   ram_addr, ram_din   RAM address / write data
//   ram_we, ram_re      RAM write / read strobes
//   ram_dout            RAM read data (registered, one cycle after ram_re)
//   busy                high outside IDLE
//   rx_drop             byte arrived while not accepting

module uart_ram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [6:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [31:0] ram_dout,
  output logic        busy,
  output logic        rx_drop
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WDATA,
    S_WRITE,
    S_READ,
    S_RCAP,
    S_TXLOAD,
    S_TXHOLD,
    S_TXWAIT
`ifdef UART_RAM_CTRL_WRACK_EN
    , S_ACK
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [6:0]  addr_q;
  logic [31:0] data_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid)
          state_d = rx_data[7] ? S_WDATA : S_READ;
      end
      S_WDATA: begin
        if (rx_valid && cnt_q == 2'd3)
          state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef UART_RAM_CTRL_WRACK_EN
        state_d = S_ACK;
`else
        state_d = S_IDLE;
`endif
      end
      S_READ:   state_d = S_RCAP;
      S_RCAP:   state_d = S_TXLOAD;
      S_TXLOAD: begin
        if (!tx_busy) state_d = S_TXHOLD;
      end
      S_TXHOLD: state_d = S_TXWAIT;
      S_TXWAIT: begin
        if (!tx_busy)
          state_d = (cnt_q == 2'd3) ? S_IDLE : S_TXLOAD;
      end
`ifdef UART_RAM_CTRL_WRACK_EN
      S_ACK: begin
        if (!tx_busy) state_d = S_TXHOLD;
      end
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // data_q doubles as write assembly register and read shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= 7'd0;
      data_q <= 32'd0;
      cnt_q  <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            addr_q <= rx_data[6:0];
            cnt_q  <= 2'd0;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            data_q <= {data_q[23:0], rx_data};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
`ifdef UART_RAM_CTRL_WRACK_EN
        // Ack reuses the TX path as a one-byte stream: count starts
        // at 3 so the first TXWAIT release returns to IDLE.
        S_WRITE: begin
          data_q <= {8'hA5, 24'd0};
          cnt_q  <= 2'd3;
        end
`endif
        S_RCAP: begin
          data_q <= ram_dout;
          cnt_q  <= 2'd0;
        end
        S_TXWAIT: begin
          if (!tx_busy) begin
            data_q <= {data_q[23:0], 8'd0};
            cnt_q  <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_start = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    busy     = 1'b1;
    rx_drop  = rx_valid;
    tx_data  = data_q[31:24];
    ram_addr = addr_q;
    ram_din  = data_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        busy    = 1'b0;
        rx_drop = 1'b0;
      end
      (state_q == S_WDATA):  rx_drop  = 1'b0;
      (state_q == S_WRITE):  ram_we   = 1'b1;
      (state_q == S_READ):   ram_re   = 1'b1;
      (state_q == S_TXLOAD): tx_start = !tx_busy;
`ifdef UART_RAM_CTRL_WRACK_EN
      (state_q == S_ACK):    tx_start = !tx_busy;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// tb_uart_ram_ctrl: directed scoreboard bench for uart_ram_ctrl.
// RAM and UART transmitter models; expectations queued at stimulus time.

module tb_uart_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [6:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_dout = 32'd0;
  logic        busy;
  logic        rx_drop;

`ifdef UART_RAM_CTRL_WRACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int drops    = 0;
  int bcnt     = 0;

  logic [38:0] wq [$];
  logic [6:0]  rq [$];
  logic [7:0]  txq [$];
  logic [31:0] mem [128];

  always #5 clk = ~clk;

  uart_ram_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_dout (ram_dout),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  // RAM with registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  // transmitter: busy for 10 cycles starting the cycle after tx_start
  always @(posedge clk) begin
    if (tx_start)      bcnt <= 10;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [38:0] w;
    if (ram_we) begin
      check("we_re_excl", 32'(ram_re), 32'd0);
      check("we_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(w[38:32]));
        check("wr_data", ram_din, w[31:0]);
      end
    end
    if (ram_re) begin
      check("re_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0)
        check("rd_addr", 32'(ram_addr), 32'(rq.pop_front()));
    end
    if (tx_start) begin
      check("tx_when_idle", 32'(tx_busy), 32'd0);
      check("tx_expected", 32'(txq.size() != 0), 32'd1);
      if (txq.size() != 0)
        check("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
    end
    if (rx_drop) drops++;
  end

  task automatic wait_idle(int n);
    int k = 0;
    @(negedge clk);
    while (busy && k < n) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wr(logic [6:0] a, logic [31:0] w);
    wq.push_back({a, w});
    if (ACK) txq.push_back(8'hA5);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = {1'b1, a};
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk); #1;
      rx_data = w[i*8 +: 8];
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("we_timing", 32'(ram_we), 32'd1);
    @(negedge clk);
    check("busy_after_wr", 32'(busy), 32'(ACK));
    wait_idle(200);
  endtask

  task automatic rd_cmd(logic [6:0] a, logic [31:0] w);
    rq.push_back(a);
    for (int i = 3; i >= 0; i--) txq.push_back(w[i*8 +: 8]);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = {1'b0, a};
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("re_timing", 32'(ram_re), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rd_latency", 32'(tx_start), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_din", ram_din, 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_re", 32'(ram_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(rx_drop), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    wr(7'h05, 32'hDEADBEEF);
    rd_cmd(7'h05, 32'hDEADBEEF);
    wait_idle(500);

    // byte during TXWAIT is dropped, stream continues
    rd_cmd(7'h05, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    d0 = drops;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h07;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("drop_pulse", 32'(drops), 32'(d0 + 1));
    wait_idle(500);

    // reset in the middle of a write: nothing reaches RAM
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h90;
    @(posedge clk); #1;
    rx_data  = 8'h11;
    @(posedge clk); #1;
    rx_data  = 8'h22;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(ram_addr), 32'd0);
    repeat (10) @(negedge clk);
    wr(7'h10, 32'hCAFEF00D);
    rd_cmd(7'h10, 32'hCAFEF00D);
    wait_idle(500);

    // address boundary
    wr(7'h00, 32'h11111111);
    wr(7'h7F, 32'h01020304);
    rd_cmd(7'h7F, 32'h01020304);
    wait_idle(500);
    rd_cmd(7'h00, 32'h11111111);
    wait_idle(500);

    repeat (20) @(negedge clk);
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("txq_drained", 32'(txq.size()), 32'd0);
    check("drop_total", 32'(drops), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_ram_ctrl.md
# uart_ram_ctrl

Command sequencer between the RS-232 byte receiver/transmitter and the 128x32 word RAM. It decodes a command byte from the UART receiver, assembles four data bytes into a 32-bit RAM write, or issues a RAM read and streams the word back through the UART transmitter. It is the only master of the RAM port, and the host link uses it for loading and dumping AES key/data words.

## Interface
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: received byte, valid when `rx_valid`=1.
- `rx_valid` input 1: one-cycle pulse per received byte.
- `tx_data` output 8: byte to transmit, held stable from `tx_start` until the transmitter's `tx_busy` falls.
- `tx_start` output 1: one-cycle transmit request; issued only when `tx_busy`=0.
- `tx_busy` input 1: transmitter busy, asserted the cycle after `tx_start`.
- `ram_addr` output 7: RAM word address.
- `ram_din` output 32: RAM write data.
- `ram_we` output 1: RAM write enable, one-cycle pulse.
- `ram_re` output 1: RAM read enable, one-cycle pulse. RAM data appears registered on the next edge.
- `ram_dout` input 32: RAM read data.
- `busy` output 1: high in every state except IDLE.
- `rx_drop` output 1: one-cycle pulse when `rx_valid` arrives in a state that does not accept bytes.

## Operation
- Command byte format:
  - bit7 = 1: write.
  - bit7 = 0: read.
  - bits6:0: address.
  - Example: 0x02 reads word 2; 0x83 writes word 3.
- Data bytes are big-endian: the first byte after the command is ram_din[31:24].
- States:
  - IDLE: on `rx_valid`, latch addr = rx_data[6:0]. Go to WDATA (bit7=1, byte counter cleared) or READ (bit7=0).
  - WDATA: each `rx_valid` shifts the byte into the data register and increments the 2-bit counter. After the 4th byte, go to WRITE.
  - WRITE: `ram_we`=1 for one cycle. Go to ACK if `UART_RAM_CTRL_WRACK_EN` is defined, else IDLE.
  - READ: `ram_re`=1 for one cycle, then RCAP.
  - RCAP: latch `ram_dout` into the shift register, clear the counter, go to TXLOAD.
  - TXLOAD: wait for `tx_busy`=0. Then pulse `tx_start` with `tx_data`=shift[31:24] and go to TXHOLD.
  - TXHOLD: one cycle; `tx_busy` is not sampled. Go to TXWAIT.
  - TXWAIT: when `tx_busy`=0, shift left 8 and increment the counter. After 4 bytes go to IDLE, else TXLOAD.
  - ACK: wait for `tx_busy`=0, pulse `tx_start` with `tx_data`=0xA5, then TXHOLD. The final `tx_busy` fall returns to IDLE.
- `rx_valid` in WRITE, READ, RCAP, TXLOAD, TXHOLD, TXWAIT or ACK: byte ignored, `rx_drop`=1 that cycle. There is no queuing.
- `ram_we` and `ram_re` are never high in the same cycle.
- `ram_addr` holds the latched addr from the command cycle until return to IDLE.
- Reset values:
  - All outputs 0.
  - State IDLE; counters, addr and data registers 0.
- `rst` mid-command, including mid-WDATA or mid-TX: abort immediately.
  - A partial write never reaches the RAM.
  - The transmitter finishes any byte already started independently.

## Timing
- Write: `ram_we` is high in the cycle after the 4th data byte's `rx_valid` cycle. `busy` falls the following cycle (without ACK).
- Read: `ram_re` is high 1 cycle after the command `rx_valid`. `ram_dout` is captured 2 cycles after it. The first `tx_start` comes 3 cycles after the command at the earliest (TX idle).
- Between bytes: minimum 3 cycles from `tx_start` to the next `tx_start`. The actual spacing is set by `tx_busy`.
- `rx_valid` on consecutive cycles is accepted in IDLE→WDATA and throughout WDATA.

## Configuration
- `UART_RAM_CTRL_WRACK_EN` defined:
  - After each write, one ack byte 0xA5 is transmitted.
  - `busy` stays high until that byte's `tx_busy` falls.
- Undefined:
  - ACK state is absent; writes are silent.
  - WRITE returns directly to IDLE.

## Test plan
- Reset, then idle: all outputs 0, `busy`=0, no spurious `ram_we`/`ram_re`/`tx_start`.
- Bytes 0x85,0xDE,0xAD,0xBE,0xEF → single `ram_we` pulse with addr=5, din=0xDEADBEEF. With WRACK_EN, one `tx_start` with 0xA5.
- Write as above, then byte 0x05 with a RAM model → `ram_re` with addr=5. Then four `tx_start` pulses carrying 0xDE,0xAD,0xBE,0xEF in order, each gated by a 10-cycle `tx_busy`. `busy` falls after the last.
- Byte 0x07 sent during TXWAIT of a previous read → `rx_drop` pulse, no new read, stream unaffected.
- `rst` after the 2nd data byte of write 0x90 → no `ram_we`. A following full write to addr 0x10 stores the new word only.
- Write to addr 0x7F with 0x01020304, then read 0x7F → bytes 0x01,0x02,0x03,0x04. Address boundary correct, no wrap to 0.
